// File: rtl/fsm_job_arbiter.sv
// Round-robin arbiter that shares one start/busy worker among N_REQ requesters.
// Issues a one-cycle start, tracks busy through the job, and returns ack or err to the owner.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no job owned; arbitrate among pending requests
// ISSUE   | start pulsed; waiting up to START_WAIT cycles for busy to rise
// RUN     | worker busy; waiting for busy to fall or the run limit
// RELEASE | grant dropped, ack/err pulse visible; pointer advances
module fsm_job_arbiter #(
    parameter int N_REQ      = 4,
    parameter int START_WAIT = 8,
    parameter int RUN_LIMIT  = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] ack,
    output logic [N_REQ-1:0] err,
    output logic             wk_start,
    input  logic             wk_busy,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ISSUE   = 2'b01,
        RUN     = 2'b10,
        RELEASE = 2'b11
    } state_t;

    localparam int CNT_MAX = (START_WAIT > RUN_LIMIT) ? START_WAIT : RUN_LIMIT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = $clog2(N_REQ);

    localparam logic [CW-1:0] START_TC     = CW'(START_WAIT - 1);
    localparam logic [CW-1:0] RUN_TC       = CW'(RUN_LIMIT - 1);
    localparam bit            RUN_LIMIT_EN = (RUN_LIMIT != 0);
    localparam logic [IW-1:0] LAST_RST     = IW'(N_REQ - 1);

    state_t           state_q, state_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic [IW-1:0]    winner_q, winner_n;
    logic [IW-1:0]    last_q, last_n;
    logic [N_REQ-1:0] gnt_q, gnt_n;
    logic [N_REQ-1:0] ack_q, ack_n;
    logic [N_REQ-1:0] err_q, err_n;
    logic             start_q, start_n;

    logic [IW-1:0]    pick;
    logic             req_any;
    int               idx;

    function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] i);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Scan from farthest to nearest offset so the nearest set bit after last_q wins.
    always_comb begin
        pick    = '0;
        req_any = 1'b0;
        idx     = 0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = (int'(last_q) + i) % N_REQ;
            if (req[IW'(idx)]) begin
                pick    = IW'(idx);
                req_any = 1'b1;
            end
        end
    end

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        winner_n = winner_q;
        last_n   = last_q;
        gnt_n    = gnt_q;
        ack_n    = '0;
        err_n    = '0;
        start_n  = 1'b0;

        case (state_q)
            IDLE: begin
                gnt_n = '0;
                if (req_any) begin
                    winner_n = pick;
                    gnt_n    = onehot(pick);
                    start_n  = 1'b1;
                    cnt_n    = '0;
                    state_n  = ISSUE;
                end
            end

            ISSUE: begin
                cnt_n = cnt_q + 1'b1;
                if (wk_busy) begin
                    cnt_n   = '0;
                    state_n = RUN;
                end else if (cnt_q == START_TC) begin
                    err_n   = onehot(winner_q);
                    gnt_n   = '0;
                    state_n = RELEASE;
                end
            end

            RUN: begin
                if (cnt_q != '1) begin
                    cnt_n = cnt_q + 1'b1;
                end
                if (!wk_busy) begin
                    ack_n   = onehot(winner_q);
                    gnt_n   = '0;
                    state_n = RELEASE;
                end else if (RUN_LIMIT_EN && (cnt_q == RUN_TC)) begin
                    err_n   = onehot(winner_q);
                    gnt_n   = '0;
                    state_n = RELEASE;
                end
            end

            RELEASE: begin
                gnt_n   = '0;
                last_n  = winner_q;
                state_n = IDLE;
            end

            default: begin
                gnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            winner_q <= '0;
            last_q   <= LAST_RST;
            gnt_q    <= '0;
            ack_q    <= '0;
            err_q    <= '0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            winner_q <= winner_n;
            last_q   <= last_n;
            gnt_q    <= gnt_n;
            ack_q    <= ack_n;
            err_q    <= err_n;
            start_q  <= start_n;
        end
    end

    assign gnt      = gnt_q;
    assign ack      = ack_q;
    assign err      = err_q;
    assign wk_start = start_q;
    assign state    = state_q;

endmodule

// File: tb/tb_fsm_job_arbiter.sv
// Randomized bench for fsm_job_arbiter against a job-timeline reference model.
// The model predicts each job's winner, outcome kind and outcome cycle arithmetically at grant time.
module tb_fsm_job_arbiter;

    localparam int N  = 4;
    localparam int SW = 8;
    localparam int RL = 10;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] gnt, ack, err;
    logic         wk_start;
    logic         wk_busy = 1'b0;
    logic [1:0]   state;

    logic         reset2 = 1'b0;
    logic [N-1:0] req2 = '0;
    logic [N-1:0] gnt2, ack2, err2;
    logic         wk_start2;
    logic         wk_busy2 = 1'b0;
    logic [1:0]   state2;

    always #5 clk = ~clk;

    fsm_job_arbiter #(.N_REQ(N), .START_WAIT(SW), .RUN_LIMIT(RL)) dut (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt), .ack(ack), .err(err),
        .wk_start(wk_start), .wk_busy(wk_busy), .state(state)
    );

    fsm_job_arbiter #(.N_REQ(N), .START_WAIT(SW), .RUN_LIMIT(0)) dut_nl (
        .clk(clk), .reset(reset2), .req(req2), .gnt(gnt2), .ack(ack2), .err(err2),
        .wk_start(wk_start2), .wk_busy(wk_busy2), .state(state2)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // stimulus applied just after each edge
    logic [N-1:0] req_nxt = '0;
    logic         rst_nxt = 1'b0;

    // worker plan for the next grant: busy rises plan_d cycles after the grant edge, lasts plan_l
    int plan_d = 1, plan_l = 1;
    bit plan_rand = 0;

    // reference model: one job timeline at a time
    bit m_job = 0;
    bit m_kind_err = 0;
    int m_w = 0, m_e0 = 0, m_d = 0, m_l = 0, m_out = 0, m_idle = 0, m_last = N - 1;

    int dut_order[$];
    int nl_err_cnt = 0, nl_ack_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int i = 1; i <= N; i++)
            if (r[(last + i) % N]) return (last + i) % N;
        return -1;
    endfunction

    function automatic logic [31:0] bit_of(input int i);
        return 32'(1) << i;
    endfunction

    task automatic model_edge();
        cyc++;
        if (reset === 1'b0) begin
            m_job  = 0;
            m_last = N - 1;
            m_idle = cyc + 1;
        end else begin
            if (m_job && cyc == m_out + 1) begin
                m_job  = 0;
                m_last = m_w;
            end
            if (!m_job && cyc >= m_idle && req != '0) begin
                m_w  = rr_pick(req, m_last);
                m_e0 = cyc;
                if (plan_rand) begin
                    m_d = $urandom_range(1, 10);
                    m_l = (m_d >= SW) ? 0 : $urandom_range(1, 14);
                end else begin
                    m_d = plan_d;
                    m_l = plan_l;
                end
                if (m_d <= SW - 1) begin
                    if (m_l > RL) begin
                        m_kind_err = 1;
                        m_out      = m_e0 + m_d + 1 + RL;
                    end else begin
                        m_kind_err = 0;
                        m_out      = m_e0 + m_d + m_l + 1;
                    end
                end else begin
                    m_kind_err = 1;
                    m_out      = m_e0 + SW;
                end
                m_idle = m_out + 2;
                m_job  = 1;
            end
        end
    endtask

    function automatic logic exp_busy();
        int rel;
        rel = cyc - m_e0;
        return m_job && (cyc < m_out) && (rel >= m_d) && (rel < m_d + m_l);
    endfunction

    function automatic logic [1:0] exp_state();
        if (!m_job) return 2'b00;
        if (cyc == m_out) return 2'b11;
        if (m_d <= SW - 1 && cyc > m_e0 + m_d) return 2'b10;
        return 2'b01;
    endfunction

    task automatic step();
        logic [31:0] e_gnt, e_ack, e_err;
        int gi;
        @(posedge clk);
        model_edge();
        #1;
        req     = req_nxt;
        reset   = rst_nxt;
        wk_busy = exp_busy();
        @(negedge clk);
        e_gnt = (m_job && cyc < m_out) ? bit_of(m_w) : 32'd0;
        e_ack = (m_job && cyc == m_out && !m_kind_err) ? bit_of(m_w) : 32'd0;
        e_err = (m_job && cyc == m_out && m_kind_err) ? bit_of(m_w) : 32'd0;
        chk("gnt", 32'(gnt), e_gnt);
        chk("ack", 32'(ack), e_ack);
        chk("err", 32'(err), e_err);
        chk("wk_start", 32'(wk_start), 32'(m_job && cyc == m_e0));
        chk("state", 32'(state), 32'(exp_state()));
        if (wk_start === 1'b1) begin
            gi = -1;
            for (int i = 0; i < N; i++) if (gnt[i] === 1'b1) gi = i;
            dut_order.push_back(gi);
        end
        if (err2 != '0) nl_err_cnt++;
        if (ack2 != '0) nl_ack_cnt++;
    endtask

    task automatic run_until_done(input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(m_job && cyc == m_out) && n < budget);
        if (!(m_job && cyc == m_out)) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_budget cyc=%0d got=expired exp=job_done", cyc);
        end
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic reset_pulse();
        rst_nxt = 1'b0;
        step();
        rst_nxt = 1'b1;
        step();
    endtask

    initial begin
        int first;
        int k;

        rst_nxt = 1'b0;
        idle_steps(3);
        rst_nxt = 1'b1;
        reset2  = 1'b1;
        req2    = 4'b0001;
        wk_busy2 = 1'b1;
        idle_steps(2);

        // single request, 5-cycle busy
        plan_d = 1; plan_l = 5;
        req_nxt = 4'b0010;
        run_until_done(50);
        req_nxt = '0;
        idle_steps(4);

        // fairness from reset
        reset_pulse();
        dut_order.delete();
        plan_d = 1; plan_l = 3;
        req_nxt = 4'b1111;
        for (int j = 0; j < 6; j++) run_until_done(50);
        req_nxt = '0;
        idle_steps(3);
        chk("fair_count", 32'(dut_order.size()), 32'd6);
        for (int j = 0; j < 6; j++) begin
            first = (j < dut_order.size()) ? dut_order[j] : -1;
            chk("fair_order", 32'(first), 32'(j % N));
        end

        // start timeout, then a normal job for the same requester
        plan_d = 99; plan_l = 0;
        req_nxt = 4'b0100;
        run_until_done(50);
        plan_d = 1; plan_l = 2;
        run_until_done(50);
        req_nxt = '0;
        idle_steps(3);

        // run limit
        plan_d = 1; plan_l = 1000;
        req_nxt = 4'b0001;
        run_until_done(60);
        req_nxt = '0;
        idle_steps(3);

        // busy rises on the same cycle the start timeout is reached
        plan_d = SW - 1; plan_l = 4;
        req_nxt = 4'b1000;
        run_until_done(50);
        req_nxt = '0;
        idle_steps(3);

        // requester drops req during RUN
        plan_d = 1; plan_l = 6;
        req_nxt = 4'b1000;
        k = 0;
        do begin step(); k++; end while (exp_state() != 2'b10 && k < 20);
        req_nxt = '0;
        run_until_done(50);
        idle_steps(3);

        // reset mid-RUN with several requests pending
        plan_d = 1; plan_l = 20;
        req_nxt = 4'b1111;
        k = 0;
        do begin step(); k++; end while (exp_state() != 2'b10 && k < 20);
        idle_steps(2);
        reset_pulse();
        dut_order.delete();
        plan_d = 1; plan_l = 2;
        run_until_done(50);
        req_nxt = '0;
        idle_steps(3);
        first = (dut_order.size() > 0) ? dut_order[0] : -1;
        chk("rst_next_gnt", 32'(first), 32'd0);

        // randomized traffic with occasional resets
        plan_rand = 1;
        for (int j = 0; j < 1200; j++) begin
            if ($urandom_range(0, 7) == 0) req_nxt = N'($urandom);
            rst_nxt = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            step();
        end
        rst_nxt = 1'b1;
        req_nxt = '0;
        idle_steps(30);

        // unlimited run instance has been busy since the start
        chk("nl_state", 32'(state2), 32'd2);
        chk("nl_gnt", 32'(gnt2), 32'd1);
        chk("nl_err_pulses", 32'(nl_err_cnt), 32'd0);
        chk("nl_ack_pulses", 32'(nl_ack_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
